fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, >= 2).
REQ-002 SHALL have parameter PHT_W, default 8, width of the gshare PHT index carried per entry.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discards all entries (redirect from EX).
REQ-006 SHALL have port enq_valid, input, 1, fetch stage presents an entry.
REQ-007 SHALL have port enq_ready, output, 1, queue accepts the entry this cycle.
REQ-008 SHALL have ports enq_pc and enq_instr, input, 32 each, fetched PC and instruction word.
REQ-009 SHALL have ports enq_pred_taken (1), enq_pht_idx (PHT_W), enq_btb_hit (1), enq_btb_target (32), input, fetch-time prediction metadata.
REQ-010 SHALL have port deq_valid, output, 1, head entry available to decode.
REQ-011 SHALL have port deq_ready, input, 1, decode consumes the head this cycle.
REQ-012 SHALL have ports deq_pc, deq_instr, deq_pred_taken, deq_pht_idx, deq_btb_hit, deq_btb_target, output, widths as enqueue side, head entry fields.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, number of valid entries.

Function
REQ-014 SHALL perform an enqueue when enq_valid & enq_ready & ~flush; the entry is written at the tail and the tail pointer advances modulo DEPTH.
REQ-015 SHALL perform a dequeue when deq_valid & deq_ready & ~flush; the head pointer advances modulo DEPTH.
REQ-016 SHALL drive enq_ready = (count < DEPTH), combinationally from registered state only; there is no full-queue pass-through even if deq_ready is high.
REQ-017 SHALL drive deq_valid = (count != 0); the deq_* payload SHALL be the head entry, read combinationally from storage (first-word fall-through).
REQ-018 SHALL NOT bypass enq to deq: an entry enqueued in cycle N is first visible on deq in cycle N+1.
REQ-019 SHALL update count +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue (allowed whenever 0 < count < DEPTH).
REQ-020 SHALL, on flush, set head, tail and count to 0 at the next edge, dropping any enqueue or dequeue in the same cycle; the cycle after flush SHALL show deq_valid = 0 and enq_ready = 1.
REQ-021 SHALL preserve FIFO order and all metadata bits unchanged across pointer wrap-around.
REQ-022 SHALL hold deq_* payload stable while deq_valid = 1 and deq_ready = 0.
REQ-023 SHALL ignore enq_* when enq_valid = 0 and ignore deq_ready when deq_valid = 0 (no pointer or count change).

Reset
REQ-024 SHALL, while rst = 1, asynchronously clear head, tail and count to 0, giving deq_valid = 0, enq_ready = 1, count = 0.
REQ-025 SHALL clear storage to 0 on reset so deq_* read 0 out of reset; reset during operation SHALL discard all entries, identical to power-up.

Structure
REQ-026 SHALL take the entry struct typedef (pc, instr, pred_taken, pht_idx, btb_hit, btb_target) and the PHT index width constant from the shared CPU package, the same constant sizing the IF-stage predictor.
REQ-027 SHALL implement storage, pointers and count inline; no sub-module is required.

Verification
REQ-028 SHALL cover: reset, enqueue pc=0x100 instr=0x00000013 pht_idx=0x5A -> next cycle deq_valid=1 with identical fields, count=1.
REQ-029 SHALL cover: DEPTH=4, enqueue 4 with deq_ready=0 -> count=4, enq_ready=0; 5th enqueue ignored; drain yields pcs 0x0,0x4,0x8,0xC in order.
REQ-030 SHALL cover: count=2, simultaneous enq and deq for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-031 SHALL cover: count=3 with enq_valid=1 and deq_ready=1, flush=1 -> next cycle count=0, deq_valid=0, flushed-cycle enqueue absent.
REQ-032 SHALL cover: rst asserted mid-cycle with count=3 -> deq_valid=0 and count=0 before the next clk edge.
REQ-033 SHALL cover: count=0, enqueue pc=0x200 -> deq_valid=0 that same cycle (no bypass), 1 the next.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared CPU types for the fetch path.
// The PHT index width also sizes the IF-stage gshare predictor.
package fetch_queue_pkg;

  localparam int PHT_IDX_W = 8;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          instr;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic                 btb_hit;
    logic [31:0]          btb_target;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// IF-to-ID fetch queue: first-word fall-through FIFO
// carrying each instruction with its branch prediction metadata.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PHT_W = PHT_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_instr,
  input  logic                       enq_pred_taken,
  input  logic [PHT_W-1:0]           enq_pht_idx,
  input  logic                       enq_btb_hit,
  input  logic [31:0]                enq_btb_target,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_instr,
  output logic                       deq_pred_taken,
  output logic [PHT_W-1:0]           deq_pht_idx,
  output logic                       deq_btb_hit,
  output logic [31:0]                deq_btb_target,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t      mem [DEPTH];
  fq_entry_t      wr_e;
  fq_entry_t      rd_e;
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CW-1:0]  cnt;
  logic           do_enq;
  logic           do_deq;

  assign enq_ready = (cnt < CW'(DEPTH));
  assign deq_valid = (cnt != '0);
  assign do_enq    = enq_valid & enq_ready & ~flush;
  assign do_deq    = deq_valid & deq_ready & ~flush;
  assign count     = cnt;

  always_comb begin
    wr_e            = '0;
    wr_e.pc         = enq_pc;
    wr_e.instr      = enq_instr;
    wr_e.pred_taken = enq_pred_taken;
    wr_e.pht_idx    = enq_pht_idx;
    wr_e.btb_hit    = enq_btb_hit;
    wr_e.btb_target = enq_btb_target;
  end

  // Head read straight from storage: no enq-to-deq bypass.
  assign rd_e           = mem[head];
  assign deq_pc         = rd_e.pc;
  assign deq_instr      = rd_e.instr;
  assign deq_pred_taken = rd_e.pred_taken;
  assign deq_pht_idx    = rd_e.pht_idx;
  assign deq_btb_hit    = rd_e.btb_hit;
  assign deq_btb_target = rd_e.btb_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) begin
        mem[tail] <= wr_e;
        tail      <= tail + 1'b1;
      end
      if (do_deq) begin
        head <= head + 1'b1;
      end
      unique case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue.
// Each task drives one scenario and checks the DUT inline.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        enq_pred_taken;
  logic [7:0]  enq_pht_idx;
  logic        enq_btb_hit;
  logic [31:0] enq_btb_target;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_pred_taken;
  logic [7:0]  deq_pht_idx;
  logic        deq_btb_hit;
  logic [31:0] deq_btb_target;
  logic [2:0]  count;

  fq_entry_t sb [$];
  int n_chk;
  int n_fail;

  fetch_queue #(.DEPTH(DEPTH), .PHT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_instr(enq_instr),
    .enq_pred_taken(enq_pred_taken),
    .enq_pht_idx(enq_pht_idx),
    .enq_btb_hit(enq_btb_hit),
    .enq_btb_target(enq_btb_target),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_pred_taken(deq_pred_taken),
    .deq_pht_idx(deq_pht_idx),
    .deq_btb_hit(deq_btb_hit),
    .deq_btb_target(deq_btb_target),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic fq_entry_t mk(input logic [31:0] pc);
    fq_entry_t e;
    e.pc         = pc;
    e.instr      = $urandom;
    e.pred_taken = 1'($urandom);
    e.pht_idx    = 8'($urandom);
    e.btb_hit    = 1'($urandom);
    e.btb_target = $urandom;
    return e;
  endfunction

  function automatic fq_entry_t act();
    fq_entry_t e;
    e.pc         = deq_pc;
    e.instr      = deq_instr;
    e.pred_taken = deq_pred_taken;
    e.pht_idx    = deq_pht_idx;
    e.btb_hit    = deq_btb_hit;
    e.btb_target = deq_btb_target;
    return e;
  endfunction

  task automatic drive_enq(input logic v, input fq_entry_t e);
    enq_valid      = v;
    enq_pc         = e.pc;
    enq_instr      = e.instr;
    enq_pred_taken = e.pred_taken;
    enq_pht_idx    = e.pht_idx;
    enq_btb_hit    = e.btb_hit;
    enq_btb_target = e.btb_target;
  endtask

  // Enqueue n entries with deq stalled; scoreboard records each.
  task automatic fill(input int n, input logic [31:0] base);
    fq_entry_t e;
    deq_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = mk(base + 32'(4 * i));
      drive_enq(1'b1, e);
      sb.push_back(e);
      tick();
    end
    drive_enq(1'b0, '0);
  endtask

  task automatic test_reset();
    n_chk++;
    if (deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_deq_valid got %0b want 0", deq_valid);
    end
    n_chk++;
    if (enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_enq_ready got %0b want 1", enq_ready);
    end
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    n_chk++;
    if (act() !== fq_entry_t'('0)) begin
      n_fail++;
      $display("FAIL reset_payload got %h want 0", act());
    end
  endtask

  task automatic test_single();
    fq_entry_t e;
    e            = mk(32'h100);
    e.instr      = 32'h0000_0013;
    e.pht_idx    = 8'h5A;
    drive_enq(1'b1, e);
    sb.push_back(e);
    tick();
    drive_enq(1'b0, '0);
    n_chk++;
    if (deq_valid !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_state got v=%0b c=%0d want v=1 c=1",
               deq_valid, count);
    end
    n_chk++;
    if (act() !== sb[0]) begin
      n_fail++;
      $display("FAIL single_fields got %h want %h", act(), sb[0]);
    end
    void'(sb.pop_front());
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    n_chk++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain got c=%0d v=%0b want 0 0",
               count, deq_valid);
    end
  endtask

  task automatic test_full();
    fq_entry_t e;
    fq_entry_t extra;
    fill(DEPTH, 32'h0);
    n_chk++;
    if (count !== 3'd4 || enq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state got c=%0d r=%0b want 4 0",
               count, enq_ready);
    end
    extra = mk(32'h10);
    drive_enq(1'b1, extra);
    tick();
    drive_enq(1'b0, '0);
    n_chk++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_5th_enq got c=%0d want 4", count);
    end
    n_chk++;
    if (act() !== sb[0]) begin
      n_fail++;
      $display("FAIL full_hold got %h want %h", act(), sb[0]);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      n_chk++;
      if (deq_valid !== 1'b1 || act() !== e) begin
        n_fail++;
        $display("FAIL full_drain%0d got v=%0b %h want %h",
                 i, deq_valid, act(), e);
      end
      tick();
    end
    deq_ready = 1'b0;
    n_chk++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL full_empty got v=%0b c=%0d want 0 0",
               deq_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    fq_entry_t e;
    fq_entry_t n;
    fill(2, 32'h1000);
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (count !== 3'd2) begin
        n_fail++;
        $display("FAIL b2b_count%0d got %0d want 2", i, count);
      end
      e = sb.pop_front();
      n_chk++;
      if (act() !== e) begin
        n_fail++;
        $display("FAIL b2b_head%0d got %h want %h", i, act(), e);
      end
      n = mk(32'h2000 + 32'(4 * i));
      drive_enq(1'b1, n);
      sb.push_back(n);
      tick();
    end
    drive_enq(1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_chk++;
      if (deq_valid !== 1'b1 || act() !== e) begin
        n_fail++;
        $display("FAIL b2b_tail%0d got %h want %h", i, act(), e);
      end
      tick();
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_flush();
    fq_entry_t e;
    fill(3, 32'h3000);
    drive_enq(1'b1, mk(32'h300));
    deq_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    deq_ready = 1'b0;
    drive_enq(1'b0, '0);
    sb.delete();
    n_chk++;
    if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state got c=%0d v=%0b r=%0b want 0 0 1",
               count, deq_valid, enq_ready);
    end
    e = mk(32'h400);
    drive_enq(1'b1, e);
    sb.push_back(e);
    tick();
    drive_enq(1'b0, '0);
    n_chk++;
    if (count !== 3'd1 || act() !== e) begin
      n_fail++;
      $display("FAIL flush_after got c=%0d %h want 1 %h",
               count, act(), e);
    end
    void'(sb.pop_front());
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    fill(3, 32'h5000);
    n_chk++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL arst_pre got c=%0d want 3", count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_state got v=%0b c=%0d want 0 0",
               deq_valid, count);
    end
    n_chk++;
    if (act() !== fq_entry_t'('0)) begin
      n_fail++;
      $display("FAIL arst_payload got %h want 0", act());
    end
    sb.delete();
    #1;
    rst = 1'b0;
    tick();
    n_chk++;
    if (enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after got r=%0b v=%0b want 1 0",
               enq_ready, deq_valid);
    end
  endtask

  task automatic test_no_bypass();
    fq_entry_t e;
    e = mk(32'h200);
    drive_enq(1'b1, e);
    sb.push_back(e);
    #2;
    n_chk++;
    if (deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nobyp_same got v=%0b want 0", deq_valid);
    end
    tick();
    drive_enq(1'b0, '0);
    n_chk++;
    if (deq_valid !== 1'b1 || act() !== e) begin
      n_fail++;
      $display("FAIL nobyp_next got v=%0b %h want 1 %h",
               deq_valid, act(), e);
    end
    void'(sb.pop_front());
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    deq_ready = 1'b0;
    drive_enq(1'b0, '0);
    #12;
    test_reset();
    rst = 1'b0;
    tick();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_no_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
